// File: rtl/ad_ip_jesd204_tpl_adc_pkg.sv
//==============================================================================
// Module   : ad_ip_jesd204_tpl_adc_pkg
// Brief    : Shared arm-FSM encodings, edge/mode selects and edge helper.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ad_ip_jesd204_tpl_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUN     = 2'd2,
        ST_ILLEGAL = 2'd3
    } sync_state_e;

    localparam logic EDGE_RISING     = 1'b0;
    localparam logic EDGE_FALLING    = 1'b1;

    localparam logic MODE_ONESHOT    = 1'b0;
    localparam logic MODE_CONTINUOUS = 1'b1;

    // True for exactly one transition of the selected polarity.
    function automatic logic edge_match(
        input logic edge_sel,
        input logic cur,
        input logic prev
    );
        if (edge_sel == EDGE_FALLING) begin
            return (~cur) & prev;
        end
        return cur & (~prev);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_adc_sync_edge.sv
//==============================================================================
// Module   : ad_ip_jesd204_tpl_adc_sync_edge
// Brief    : Multi-flop synchroniser plus registered single-cycle edge detect.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ad_ip_jesd204_tpl_adc_sync_edge
    import ad_ip_jesd204_tpl_adc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    input  logic edge_sel_i,
    output logic trig_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   trig_q;
    logic                   trig_d;

    assign trig_d = edge_match(edge_sel_i, sync_q[SYNC_STAGES-1], hist_q);

    // Latency from async_i to trig_o is SYNC_STAGES + 1 rising edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            trig_q <= trig_d;
        end
    end

    assign trig_o = trig_q;

endmodule

`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_adc_sync_ctrl.sv
//==============================================================================
// Module   : ad_ip_jesd204_tpl_adc_sync_ctrl
// Brief    : External-trigger arm/run controller gating ADC channel valids.
//            Interval measurement built only with AD_IP_JESD204_TPL_ADC_SYNC_DEBUG_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ad_ip_jesd204_tpl_adc_sync_ctrl
    import ad_ip_jesd204_tpl_adc_pkg::*;
#(
    parameter int NUM_CHANNELS  = 1,
    parameter int COUNTER_WIDTH = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adc_sync,
    input  logic                     sync_mode,
    input  logic                     sync_edge,
    input  logic                     adc_external_sync,
    input  logic                     link_valid,
    output logic [NUM_CHANNELS-1:0]  adc_valid,
    output logic                     adc_sync_status,
    output logic                     adc_rst_sync,
    output logic [COUNTER_WIDTH-1:0] trigger_count,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic                     period_valid,
    output logic                     period_ovf,
    output logic [1:0]               fsm_state
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic                     trig;
    sync_state_e              state_q;
    sync_state_e              state_d;
    logic                     accept_d;
    logic                     rst_pulse_d;
    logic                     rst_pulse_q;
    logic [COUNTER_WIDTH-1:0] trig_cnt_q;

    ad_ip_jesd204_tpl_adc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .async_i    (adc_external_sync),
        .edge_sel_i (sync_edge),
        .trig_o     (trig)
    );

    // adc_sync always wins; a trig arriving in the same cycle is dropped.
    always_comb begin
        state_d     = state_q;
        accept_d    = 1'b0;
        rst_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (adc_sync) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (adc_sync) begin
                    state_d = ST_IDLE;
                end else if (trig) begin
                    state_d  = ST_RUN;
                    accept_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (adc_sync) begin
                    state_d = ST_ARMED;
                end else if (trig && (sync_mode == MODE_CONTINUOUS)) begin
                    accept_d    = 1'b1;
                    rst_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rst_pulse_q <= 1'b0;
            trig_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rst_pulse_q <= rst_pulse_d;
            if (accept_d) begin
                trig_cnt_q <= trig_cnt_q + CNT_ONE;
            end
        end
    end

    assign adc_sync_status = (state_q == ST_ARMED);
    assign adc_rst_sync    = (state_q == ST_ARMED) | rst_pulse_q;
    assign adc_valid       = (state_q == ST_ARMED) ? '0 : {NUM_CHANNELS{link_valid}};
    assign trigger_count   = trig_cnt_q;
    assign fsm_state       = state_q;

`ifdef AD_IP_JESD204_TPL_ADC_SYNC_DEBUG_EN
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

    logic                     enter_idle_d;
    logic                     meas_active_q;
    logic [COUNTER_WIDTH-1:0] interval_q;
    logic [COUNTER_WIDTH-1:0] period_q;
    logic                     period_valid_q;
    logic                     period_ovf_q;

    assign enter_idle_d = (state_d == ST_IDLE) && (state_q != ST_IDLE);

    // Interval restarts at 1 on every accepted trig and saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_active_q  <= 1'b0;
            interval_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            period_ovf_q   <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (enter_idle_d) begin
                meas_active_q <= 1'b0;
                interval_q    <= '0;
            end else if (accept_d) begin
                if (meas_active_q) begin
                    period_q       <= interval_q;
                    period_valid_q <= 1'b1;
                end
                meas_active_q <= 1'b1;
                interval_q    <= CNT_ONE;
            end else if (meas_active_q) begin
                if (interval_q == CNT_MAX) begin
                    period_ovf_q <= 1'b1;
                end else begin
                    interval_q <= interval_q + CNT_ONE;
                end
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign period_ovf   = period_ovf_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
    assign period_ovf   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_adc_sync_ctrl.sv
//==============================================================================
// Module   : tb_ad_ip_jesd204_tpl_adc_sync_ctrl
// Brief    : Directed self-checking bench with a trigger scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ad_ip_jesd204_tpl_adc_sync_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int SS  = 2;
`ifdef AD_IP_JESD204_TPL_ADC_SYNC_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           adc_sync;
    logic           sync_mode;
    logic           sync_edge;
    logic           ext;
    logic           link_valid;
    logic [NCH-1:0] adc_valid;
    logic           adc_sync_status;
    logic           adc_rst_sync;
    logic [CW-1:0]  trigger_count;
    logic [CW-1:0]  period;
    logic           period_valid;
    logic           period_ovf;
    logic [1:0]     fsm_state;

    ad_ip_jesd204_tpl_adc_sync_ctrl #(
        .NUM_CHANNELS  (NCH),
        .COUNTER_WIDTH (CW),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .adc_sync          (adc_sync),
        .sync_mode         (sync_mode),
        .sync_edge         (sync_edge),
        .adc_external_sync (ext),
        .link_valid        (link_valid),
        .adc_valid         (adc_valid),
        .adc_sync_status   (adc_sync_status),
        .adc_rst_sync      (adc_rst_sync),
        .trigger_count     (trigger_count),
        .period            (period),
        .period_valid      (period_valid),
        .period_ovf        (period_ovf),
        .fsm_state         (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cnt;
        int    per;
        bit    pv;
        bit    ovf;
        bit    rst;
    } exp_t;

    exp_t sb_q[$];
    int   exp_count   = 0;
    int   last_period = 0;
    bit   exp_ovf     = 1'b0;
    int   n_checks    = 0;
    int   n_pass      = 0;
    int   n_fail      = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive a trigger edge that must be accepted; interval < 0 means no measurement yet.
    task automatic push_edge(input string tag, input bit lvl, input int interval, input bit rst);
        exp_t e;
        ext       = lvl;
        exp_count = (exp_count + 1) % (1 << CW);
        e.pv      = 1'b0;
        if (DBG && interval >= 0) begin
            last_period = (interval > 255) ? 255 : interval;
            e.pv        = 1'b1;
            if (interval > 255) exp_ovf = 1'b1;
        end
        e.tag = tag;
        e.cnt = exp_count;
        e.per = last_period;
        e.ovf = exp_ovf;
        e.rst = rst;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            n_pass++;
            e = sb_q.pop_front();
            chk({e.tag, ".state"}, 32'(fsm_state), 32'd2);
            chk({e.tag, ".count"}, 32'(trigger_count), 32'(e.cnt));
            chk({e.tag, ".period"}, 32'(period), 32'(e.per));
            chk({e.tag, ".pvalid"}, 32'(period_valid), 32'(e.pv));
            chk({e.tag, ".ovf"}, 32'(period_ovf), 32'(e.ovf));
            chk({e.tag, ".rst_sync"}, 32'(adc_rst_sync), 32'(e.rst));
        end
    endtask

    initial begin
        reset      = 1'b1;
        adc_sync   = 1'b0;
        sync_mode  = 1'b0;
        sync_edge  = 1'b0;
        ext        = 1'b0;
        link_valid = 1'b1;
        tick(3);
        chk("rst.state", 32'(fsm_state), 32'd0);
        chk("rst.count", 32'(trigger_count), 32'd0);
        chk("rst.status", 32'(adc_sync_status), 32'd0);
        chk("rst.rst_sync", 32'(adc_rst_sync), 32'd0);
        chk("rst.period", 32'(period), 32'd0);
        chk("rst.ovf", 32'(period_ovf), 32'd0);
        chk("rst.valid", 32'(adc_valid), 32'hF);
        reset = 1'b0;
        tick(2);

        // Arm, then rising external edge in one-shot mode
        adc_sync = 1'b1;
        tick(1);
        adc_sync = 1'b0;
        chk("arm.state", 32'(fsm_state), 32'd1);
        chk("arm.valid", 32'(adc_valid), 32'h0);
        chk("arm.status", 32'(adc_sync_status), 32'd1);
        chk("arm.rst_sync", 32'(adc_rst_sync), 32'd1);
        push_edge("first", 1'b1, -1, 1'b0);
        tick(3);
        chk("first.still_armed", 32'(fsm_state), 32'd1);
        tick(1);
        pop_chk();
        chk("first.valid", 32'(adc_valid), 32'hF);
        tick(46);
        ext = 1'b0;
        tick(50);
        ext = 1'b1;
        tick(6);
        chk("oneshot.count", 32'(trigger_count), 32'(exp_count));
        chk("oneshot.rst_sync", 32'(adc_rst_sync), 32'd0);
        ext = 1'b0;
        tick(10);

        // RUN -> ARMED -> IDLE (clears measurement) -> ARMED, continuous mode
        adc_sync = 1'b1;
        tick(1);
        chk("rearm.state", 32'(fsm_state), 32'd1);
        tick(1);
        chk("abort.state", 32'(fsm_state), 32'd0);
        tick(1);
        adc_sync  = 1'b0;
        sync_mode = 1'b1;
        push_edge("cont0", 1'b1, -1, 1'b0);
        tick(4);
        pop_chk();
        tick(46);
        ext = 1'b0;
        tick(50);
        push_edge("cont1", 1'b1, 100, 1'b1);
        tick(4);
        pop_chk();
        tick(1);
        chk("cont1.pv_end", 32'(period_valid), 32'd0);
        chk("cont1.pulse_end", 32'(adc_rst_sync), 32'd0);
        tick(45);
        ext = 1'b0;
        tick(50);
        push_edge("cont2", 1'b1, 100, 1'b1);
        tick(4);
        pop_chk();
        tick(46);
        ext = 1'b0;
        tick(250);

        // Interval longer than the 8-bit counter range
        push_edge("ovf", 1'b1, 300, 1'b1);
        tick(4);
        pop_chk();
        tick(46);
        ext = 1'b0;
        tick(50);
        push_edge("ovf_sticky", 1'b1, 100, 1'b1);
        tick(4);
        pop_chk();
        tick(46);
        ext = 1'b0;
        tick(10);

        // adc_sync coincident with trig while ARMED
        adc_sync = 1'b1;
        tick(1);
        adc_sync = 1'b0;
        chk("coin.armed", 32'(fsm_state), 32'd1);
        ext = 1'b1;
        tick(3);
        adc_sync = 1'b1;
        tick(1);
        adc_sync = 1'b0;
        chk("coin.state", 32'(fsm_state), 32'd0);
        chk("coin.count", 32'(trigger_count), 32'(exp_count));
        tick(5);
        chk("coin.count_hold", 32'(trigger_count), 32'(exp_count));

        // Edges in IDLE are ignored
        ext = 1'b0;
        tick(10);
        ext = 1'b1;
        tick(10);
        chk("idle.count", 32'(trigger_count), 32'(exp_count));
        chk("idle.state", 32'(fsm_state), 32'd0);
        ext = 1'b0;
        tick(10);

        // Falling-edge selection
        adc_sync  = 1'b1;
        sync_edge = 1'b1;
        tick(1);
        adc_sync = 1'b0;
        ext      = 1'b1;
        tick(8);
        chk("fall.rise_ignored", 32'(fsm_state), 32'd1);
        chk("fall.count_hold", 32'(trigger_count), 32'(exp_count));
        push_edge("fall", 1'b0, -1, 1'b0);
        tick(3);
        chk("fall.still_armed", 32'(fsm_state), 32'd1);
        tick(1);
        pop_chk();

        // Reset mid-interval
        tick(20);
        link_valid = 1'b0;
        reset      = 1'b1;
        #1;
        exp_count   = 0;
        last_period = 0;
        exp_ovf     = 1'b0;
        chk("mrst.state", 32'(fsm_state), 32'd0);
        chk("mrst.count", 32'(trigger_count), 32'd0);
        chk("mrst.period", 32'(period), 32'd0);
        chk("mrst.ovf", 32'(period_ovf), 32'd0);
        chk("mrst.status", 32'(adc_sync_status), 32'd0);
        chk("mrst.valid", 32'(adc_valid), 32'h0);
        tick(1);
        chk("mrst.edge_state", 32'(fsm_state), 32'd0);
        chk("mrst.edge_rst_sync", 32'(adc_rst_sync), 32'd0);
        chk("mrst.edge_pvalid", 32'(period_valid), 32'd0);
        reset    = 1'b0;
        adc_sync = 1'b1;
        tick(1);
        adc_sync = 1'b0;
        chk("post.armed", 32'(fsm_state), 32'd1);
        tick(8);
        chk("post.no_trig", 32'(fsm_state), 32'd1);
        chk("post.count", 32'(trigger_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
